// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute controller that walks a small instruction ROM,
// strobes an external ALU, handshakes operand loads and reports the result.
// Outputs are a pure decode of the registered state and instruction register.
module alu_sequencer #(
  parameter int MAX_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] prog_sel,
  output logic [1:0] prog,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic [1:0] alu_ra,
  output logic [1:0] alu_rb,
  output logic       load_req,
  output logic       load_sel,
  input  logic       load_ack,
  output logic       out_valid,
  output logic [1:0] out_reg,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXEC      = 3'd2,
    S_WAIT_LOAD = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  // Opcodes 0000..1000 are plain ALU operations (add .. mov).
  localparam logic [3:0] OP_LAST_ALU = 4'h8;
  localparam logic [3:0] OP_LDA      = 4'h9;
  localparam logic [3:0] OP_LDB      = 4'hA;
  localparam logic [3:0] OP_OUT      = 4'hB;

  // Step counter saturates at MAX_STEPS (<= 255), so eight bits suffice.
  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

  state_t     state_q, state_d;
  logic [1:0] prog_q,  prog_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] ir_q,    ir_d;
  logic [7:0] step_q,  step_d;

  logic [3:0] opcode;
  logic [7:0] step_inc;
  logic       step_limit_hit;
  logic       is_alu_op;
  logic       is_load_op;

  assign opcode         = ir_q[7:4];
  assign step_inc       = step_q + 8'd1;
  assign step_limit_hit = (step_inc == STEP_LIMIT);
  assign is_alu_op      = (opcode <= OP_LAST_ALU);
  assign is_load_op     = (opcode == OP_LDA) || (opcode == OP_LDB);

  // Next-state logic: program control, instruction capture and step accounting.
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    step_d  = step_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          prog_d  = prog_sel;
          addr_d  = 8'd0;
          step_d  = 8'd0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_alu_op) begin
          // ALU instruction completes in this cycle.
          addr_d  = addr_q + 8'd1;
          step_d  = step_inc;
          state_d = step_limit_hit ? S_ERROR : S_FETCH;
        end else if (is_load_op) begin
          state_d = S_WAIT_LOAD;
        end else if (opcode == OP_OUT) begin
          // Address stays on the out instruction so it is visible afterwards.
          state_d = S_DONE;
        end else begin
          state_d = S_ERROR;
        end
      end

      S_WAIT_LOAD: begin
        // Load instruction completes on the cycle the operand is acknowledged.
        if (load_ack) begin
          addr_d  = addr_q + 8'd1;
          step_d  = step_inc;
          state_d = step_limit_hit ? S_ERROR : S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state and the held instruction only.
  always_comb begin
    alu_en    = 1'b0;
    load_req  = 1'b0;
    load_sel  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    case (state_q)
      S_FETCH: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy      = 1'b1;
        alu_en    = is_alu_op;
        out_valid = (opcode == OP_OUT);
      end
      S_WAIT_LOAD: begin
        busy     = 1'b1;
        load_req = 1'b1;
        load_sel = (opcode == OP_LDB);
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign alu_op  = ir_q[7:4];
  assign alu_ra  = ir_q[3:2];
  assign alu_rb  = ir_q[1:0];
  assign out_reg = ir_q[3:2];
  assign prog    = prog_q;
  assign address = addr_q;

  // State registers with asynchronous clear back to an idle, quiet controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prog_q  <= 2'd0;
      addr_q  <= 8'd0;
      ir_q    <= 8'd0;
      step_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 32 (legal 1..255): instructions completed without reaching an out instruction before the error state.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin program; sampled only in IDLE, DONE, ERROR.
REQ-005 SHALL have port prog_sel  input  2  program number; latched when start is accepted.
REQ-006 SHALL have port prog  output  2  latched program number to instruction ROM.
REQ-007 SHALL have port address  output  8  program counter to instruction ROM.
REQ-008 SHALL have port instruction  input  8  ROM word, combinational from prog/address; [7:4] opcode, [3:2] first reg, [1:0] second reg.
REQ-009 SHALL have port alu_en  output  1  one-cycle execute strobe.
REQ-010 SHALL have ports alu_op (output, 4), alu_ra (output, 2), alu_rb (output, 2): opcode and register fields of the held instruction.
REQ-011 SHALL have ports load_req (output, 1), load_sel (output, 1; 0=A, 1=B), load_ack (input, 1): operand-load handshake.
REQ-012 SHALL have ports out_valid (output, 1) and out_reg (output, 2): result-display strobe and source register.
REQ-013 SHALL have ports busy, done, error (output, 1 each): status.

Function
REQ-014 SHALL use states IDLE, FETCH, EXEC, WAIT_LOAD, DONE, ERROR; outputs SHALL be decoded from registered state and the instruction register ir only.
REQ-015 In IDLE/DONE/ERROR with start=1: SHALL latch prog_sel into prog, clear address and step count, and go to FETCH; start in any other state SHALL be ignored.
REQ-016 FETCH SHALL last one cycle, capture instruction into ir, and go to EXEC.
REQ-017 EXEC with opcode 0000-0111 or 1000 (add, sub, mul, div, shl, shr, sqa, sqb, mov): alu_en=1 for exactly that cycle; alu_op=ir[7:4], alu_ra=ir[3:2], alu_rb=ir[1:0]; address+1; go to FETCH.
REQ-018 EXEC with 1001 (lda) or 1010 (ldb): go to WAIT_LOAD; load_sel = 0 for lda, 1 for ldb.
REQ-019 WAIT_LOAD: load_req=1 and address held; on a cycle with load_ack=1, address+1 and go to FETCH; load_req SHALL be 0 in every other state.
REQ-020 EXEC with 1011 (out): out_valid=1 for exactly that cycle, out_reg=ir[3:2]; go to DONE; address not incremented.
REQ-021 EXEC with 1100-1111: no strobe; go to ERROR.
REQ-022 Each completed non-out instruction SHALL increment the step count; when the count reaches MAX_STEPS, SHALL go to ERROR instead of FETCH.
REQ-023 address SHALL increment modulo 256; with MAX_STEPS <= 255, wrap SHALL be unreachable.
REQ-024 busy=1 in FETCH, EXEC, WAIT_LOAD; done=1 only in DONE; error=1 only in ERROR; both held until the next accepted start.
REQ-025 load_ack outside WAIT_LOAD SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, prog=0, address=0, ir=0, step count=0, and alu_en, load_req, load_sel, out_valid, busy, done, error all 0, regardless of state.
REQ-027 After rst falls, no action SHALL occur until start is sampled high.

Verification
REQ-028 prog_sel=0 (lda r0; ldb r1; mul r0,r1; shl r0; out r0), load_ack tied high, start sampled at edge E0 -> load_req high after E2 and E5; alu_en after E7 (op 0010, ra 00, rb 01) and after E9 (op 0100, ra 00); out_valid after E11 with out_reg=00; done high after E12; address=4.
REQ-029 prog_sel=1 (lda r0; out r0), load_ack high -> out_valid after E4; done after E5; prog=01.
REQ-030 load_ack withheld 5 cycles in WAIT_LOAD -> load_req high and address stable throughout, no alu_en; FETCH one cycle after ack is sampled.
REQ-031 MAX_STEPS=1, prog_sel=1 -> error high after lda completes; no out_valid.
REQ-032 rst pulsed during WAIT_LOAD -> all outputs 0 within the same cycle; subsequent load_ack ignored; a new start reruns from address 0.
REQ-033 start pulsed while busy -> ignored, prog unchanged; start in DONE -> restart, done clears after the next edge.
